// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, reads the instruction memory combinationally and
// hands {pc, instr} pairs to decode through a two-entry FIFO whose head is registered.
module if_fetch #(
    parameter int                  PC_WIDTH = 32,
    parameter int                  DATA_W   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                n_rst,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [DATA_W-1:0]   imem_data,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_instr,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [1:0]          buf_count
);

    logic [PC_WIDTH-1:0] pc;
    logic                head_valid;
    logic [PC_WIDTH-1:0] head_pc;
    logic [DATA_W-1:0]   head_instr;
    logic                tail_valid;
    logic [PC_WIDTH-1:0] tail_pc;
    logic [DATA_W-1:0]   tail_instr;

    logic pop;
    logic fetch;
    logic fill_head;
    logic fill_tail;

    assign imem_addr = pc;
    assign out_valid = head_valid;
    assign out_pc    = head_pc;
    assign out_instr = head_instr;
    assign buf_count = {1'b0, head_valid} + {1'b0, tail_valid};

    // The tail is only ever occupied while the head is, so a free tail means count < 2.
    assign pop   = head_valid & out_ready;
    assign fetch = ~redirect_valid & (~tail_valid | pop);

    // Head slot is refilled whenever it is empty or drained this edge; the new word goes
    // to the tail only when the head will still (or again) hold an older entry.
    assign fill_head = ~head_valid | pop;
    assign fill_tail = fetch & ((head_valid & ~pop) | tail_valid);

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            pc         <= RESET_PC;
            head_valid <= 1'b0;
            head_pc    <= '0;
            head_instr <= '0;
            tail_valid <= 1'b0;
            tail_pc    <= '0;
            tail_instr <= '0;
        end else if (redirect_valid) begin
            pc         <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
            head_valid <= 1'b0;
            tail_valid <= 1'b0;
        end else begin
            if (fetch) begin
                pc <= pc + PC_WIDTH'(4);
            end

            if (fill_head) begin
                if (tail_valid) begin
                    head_valid <= 1'b1;
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                end else if (fetch) begin
                    head_valid <= 1'b1;
                    head_pc    <= pc;
                    head_instr <= imem_data;
                end else begin
                    head_valid <= 1'b0;
                end
            end

            if (fill_tail) begin
                tail_valid <= 1'b1;
                tail_pc    <= pc;
                tail_instr <= imem_data;
            end else if (pop) begin
                tail_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory read address.
- Captures the combinational 32-bit little-endian instruction word the memory returns in the same cycle.
- Delivers {pc, instr} pairs to decode through a 2-entry buffer with a valid/ready handshake; supports redirect (branch/jump) with flush.

Parameters:
- PC_WIDTH, 32, width of PC and memory byte address.
- DATA_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
- clk  input  1  single clock, rising-edge.
- n_rst  input  1  reset; asynchronous and active-high (asserted = 1).
- imem_addr  output  PC_WIDTH  byte address to instruction memory; equals the current PC.
- imem_data  input  DATA_W  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  one-cycle request to load a new PC and flush.
- redirect_pc  input  PC_WIDTH  target PC for redirect.
- out_valid  output  1  buffer head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  DATA_W  instruction at buffer head.
- out_pc  output  PC_WIDTH  PC of out_instr.
- buf_count  output  2  occupancy 0..2, for debug/verification.

Behaviour:
- Reset (n_rst=1, async):
  - pc = RESET_PC; buffer count = 0; out_valid = 0; out_instr = 0; out_pc = 0; buf_count = 0.
  - Takes effect immediately, not at the next edge.
  - Reset mid-operation discards all buffered entries and any pending redirect.
- imem_addr = pc at all times (combinational from the pc register).
- pop = out_valid & out_ready.
- fetch = ~redirect_valid & ((count < 2) | pop).
- On a fetch edge:
  - Push {pc, imem_data} into the buffer tail.
  - pc <= pc + 4, modulo 2^PC_WIDTH; 0xFFFFFFFC wraps to 0x00000000.
- On a pop edge, remove the head. Push and pop in the same cycle is legal at count 0 (an empty buffer cannot pop), 1 or 2; the count changes by push − pop.
- Full (count = 2) with out_ready = 0: no fetch; pc holds; imem_addr stable.
- Empty: out_valid = 0; out_instr and out_pc hold their last values (don't-care for decode).
- Buffer organisation: 2-entry FIFO with registered head.
  - out_instr/out_pc come from registers, not from imem_data.
  - The head is never combinational from the memory.
- Latency:
  - A PC presented on imem_addr in cycle N appears as out_valid/out_pc in cycle N+1 when the buffer is empty.
  - Sustained throughput is 1 instruction/cycle while out_ready = 1.
- Redirect (redirect_valid = 1 at an edge):
  - pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}; the low 2 bits are forced to 0.
  - count <= 0; out_valid = 0 in the next cycle.
  - No push that edge. An out_ready in the redirect cycle is ignored: the flushed head is not considered consumed.
  - First redirected instruction: out_valid = 1 two cycles after the redirect cycle (redirect edge, then fetch edge).
  - Redirect has priority over fetch and pop. Redirect during reset is ignored.
- Ordering: instructions leave in strictly increasing PC order (mod wrap) between redirects; no duplication and no drops under any out_ready pattern.
- No X propagation: with valid imem_data, every output is known from reset onward.

Test Plan:
- Reset and streaming: RESET_PC=0, memory words 0x00000013, 0x00100093, 0x00200113 at byte addresses 0/4/8, out_ready=1 -> first cycle after reset release imem_addr=0; then out_pc=0,4,8 on consecutive cycles with out_instr matching; buf_count stays 1.
- Backpressure: out_ready=0 from reset -> buf_count reaches 2 after two edges; imem_addr holds at 8; out_pc stays 0. Raise out_ready for 4 cycles -> out_pc 0,4,8,12 with no gap or duplicate.
- Redirect while full: buffer holds pc 0,4; assert redirect_valid with redirect_pc=0x40 and out_ready=1 -> next cycle out_valid=0, buf_count=0, imem_addr=0x40; following cycle out_pc=0x40.
- Misaligned redirect: redirect_pc=0x47 -> imem_addr becomes 0x44; the next delivered out_pc is 0x44.
- Wrap-around: redirect to 0xFFFFFFFC with out_ready=1 -> out_pc 0xFFFFFFFC then 0x00000000.
- Async reset mid-stream: assert n_rst between edges with buf_count=2 -> out_valid=0 and imem_addr=RESET_PC immediately, before the next clk edge; normal streaming resumes after release.
